// File: rtl/ml_vec_mac_pkg.sv
// Shared definitions for the ml_vec_mac vector MAC: FSM states, register map
// and CTRL/STATUS bit positions.
package ml_vec_mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] ADDR_A      = 8'h00;
  localparam logic [7:0] ADDR_B      = 8'h40;
  localparam logic [7:0] ADDR_CTRL   = 8'h80;
  localparam logic [7:0] ADDR_STATUS = 8'h84;
  localparam logic [7:0] ADDR_RES_LO = 8'h88;
  localparam logic [7:0] ADDR_RES_HI = 8'h8C;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_ACCUM   = 1;
  localparam int unsigned CTRL_IE      = 2;
  localparam int unsigned CTRL_LEN_LSB = 8;
  localparam int unsigned CTRL_LEN_W   = 5;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_OVF  = 2;

endpackage

// File: rtl/ml_mac_unit.sv
// Signed multiply-accumulate datapath: one registered product stage feeding a
// wrapping accumulator with sticky signed-overflow detection.
module ml_mac_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              keep,
  input  logic              ovf_clr,
  input  logic              mul_en,
  input  logic [ACC_W-1:0]  init_val,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc_nxt,
  output logic              ovf
);

  logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0]           p_q, acc_q, sum;
  logic                       p_vld, step_ovf;

  assign a_ext = (2*DATA_W)'(signed'(a));
  assign b_ext = (2*DATA_W)'(signed'(b));
  assign prod  = a_ext * b_ext;

  assign sum      = acc_q + p_q;
  // Overflow: both addends share a sign that the wrapped sum does not.
  assign step_ovf = p_vld && (acc_q[ACC_W-1] == p_q[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign acc_nxt  = p_vld ? sum : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      p_q   <= '0;
      p_vld <= 1'b0;
      ovf   <= 1'b0;
    end else if (start) begin
      acc_q <= keep ? init_val : '0;
      p_q   <= '0;
      p_vld <= 1'b0;
      ovf   <= keep ? ovf : 1'b0;
    end else begin
      acc_q <= acc_nxt;
      p_vld <= mul_en;
      if (mul_en) p_q <= ACC_W'(prod);
      if (step_ovf)     ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/ml_vec_mac.sv
// ml_vec_mac: memory-mapped signed vector dot-product engine with accumulate mode.
// Define ML_VEC_MAC_IRQ_EN to add the level completion interrupt (irq port, CTRL.IE).
module ml_vec_mac
  import ml_vec_mac_pkg::*;
#(
  parameter int unsigned VEC_LEN = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic [31:0] w_data,
  input  logic        w_en,
  input  logic        r_en,
  output logic [31:0] r_data
`ifdef ML_VEC_MAC_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [4:0] VLEN5 = 5'(VEC_LEN);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  a_reg [VEC_LEN];
  logic [DATA_W-1:0]  b_reg [VEC_LEN];
  logic [DATA_W-1:0]  a_sel, b_sel;
  logic [4:0]         ctrl_len, len_eff, cnt;
  logic               ctrl_accum, ctrl_ie;
  logic [ACC_W-1:0]   result, acc_nxt;
  logic signed [63:0] res64;
  logic               ovf;
  logic [7:0]         word;
  logic               busy, wr_ctrl, wr_status, start_req, done_clr, ovf_clr;
  logic               mul_en, run_last;
  logic [31:0]        rd_val;
  logic               unused_bits;

  assign word      = {addr[7:2], 2'b00};
  assign busy      = (state == S_RUN);
  assign wr_ctrl   = w_en && (word == ADDR_CTRL);
  assign wr_status = w_en && (word == ADDR_STATUS);
  assign start_req = wr_ctrl && !busy && w_data[CTRL_START];
  assign done_clr  = wr_status && w_data[ST_DONE];
  assign ovf_clr   = wr_status && w_data[ST_OVF];
  assign len_eff   = (ctrl_len == '0 || ctrl_len > VLEN5) ? VLEN5 : ctrl_len;
  assign res64     = 64'(signed'(result));
  assign unused_bits = ^{addr[1:0], w_data};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // The product stage adds one edge, so the final accumulate lands on edge LEN+1.
  always_comb begin
    state_nxt = state;
    mul_en    = 1'b0;
    run_last  = 1'b0;
    case (state)
      S_IDLE: if (start_req) state_nxt = S_RUN;
      S_RUN: begin
        if (cnt == len_eff) begin
          state_nxt = S_DONE;
          run_last  = 1'b1;
        end else begin
          mul_en = 1'b1;
        end
      end
      S_DONE: begin
        if (start_req)     state_nxt = S_RUN;
        else if (done_clr) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < VEC_LEN; i++) begin
      if (cnt == 5'(i)) begin
        a_sel = a_reg[i];
        b_sel = b_reg[i];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (word)
      ADDR_CTRL: begin
        rd_val[CTRL_LEN_LSB +: CTRL_LEN_W] = ctrl_len;
        rd_val[CTRL_ACCUM]                 = ctrl_accum;
        rd_val[CTRL_IE]                    = ctrl_ie;
      end
      ADDR_STATUS: begin
        rd_val[ST_BUSY] = busy;
        rd_val[ST_DONE] = (state == S_DONE);
        rd_val[ST_OVF]  = ovf;
      end
      ADDR_RES_LO: rd_val = res64[31:0];
      ADDR_RES_HI: rd_val = res64[63:32];
      default: begin
        for (int unsigned i = 0; i < VEC_LEN; i++) begin
          if (word == ADDR_A + 8'(4 * i)) rd_val = 32'(signed'(a_reg[i]));
          if (word == ADDR_B + 8'(4 * i)) rd_val = 32'(signed'(b_reg[i]));
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < VEC_LEN; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
      ctrl_len   <= '0;
      ctrl_accum <= 1'b0;
      cnt        <= '0;
      result     <= '0;
      r_data     <= '0;
    end else begin
      if (w_en && !busy) begin
        for (int unsigned i = 0; i < VEC_LEN; i++) begin
          if (word == ADDR_A + 8'(4 * i)) a_reg[i] <= w_data[DATA_W-1:0];
          if (word == ADDR_B + 8'(4 * i)) b_reg[i] <= w_data[DATA_W-1:0];
        end
        if (wr_ctrl) begin
          ctrl_len   <= w_data[CTRL_LEN_LSB +: CTRL_LEN_W];
          ctrl_accum <= w_data[CTRL_ACCUM];
        end
      end
      if (start_req)   cnt <= '0;
      else if (mul_en) cnt <= cnt + 5'd1;
      // RESULT is a shadow of the accumulator, refreshed only on completion.
      if (run_last) result <= acc_nxt;
      if (r_en)     r_data <= rd_val;
    end
  end

`ifdef ML_VEC_MAC_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_ie <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl && !busy) ctrl_ie <= w_data[CTRL_IE];
      irq <= (state == S_DONE) && ctrl_ie;
    end
  end
`else
  assign ctrl_ie = 1'b0;
`endif

  ml_mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .start   (start_req),
    .keep    (w_data[CTRL_ACCUM]),
    .ovf_clr (ovf_clr),
    .mul_en  (mul_en),
    .init_val(result),
    .a       (a_sel),
    .b       (b_sel),
    .acc_nxt (acc_nxt),
    .ovf     (ovf)
  );

endmodule

// File: tb/tb_ml_vec_mac.sv
// Self-checking bench for ml_vec_mac: table-driven register sequences plus
// hand-written timing, overflow, read/write-collision and reset-abort cases.
module tb_ml_vec_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [31:0] w_data;
  logic        w_en, r_en;
  logic [31:0] r_data, r_data32;
`ifdef ML_VEC_MAC_IRQ_EN
  logic        irq, irq32;
`endif

  int checks = 0;
  int errors = 0;

  localparam int OP_WR = 0;
  localparam int OP_RD = 1;
  localparam int OP_IDLE = 2;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  ml_vec_mac dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .w_data(w_data),
    .w_en  (w_en),
    .r_en  (r_en),
    .r_data(r_data)
`ifdef ML_VEC_MAC_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  ml_vec_mac #(
    .VEC_LEN(8),
    .DATA_W (16),
    .ACC_W  (32)
  ) dut32 (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .w_data(w_data),
    .w_en  (w_en),
    .r_en  (r_en),
    .r_data(r_data32)
`ifdef ML_VEC_MAC_IRQ_EN
    ,
    .irq   (irq32)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; w_data = d; w_en = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    @(negedge clk);
    addr = a; r_en = 1'b1;
    @(posedge clk); #1;
    r_en = 1'b0;
  endtask

  task automatic rw(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; w_data = d; w_en = 1'b1; r_en = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int k, input logic [7:0] a, input logic [31:0] d,
                              input logic [31:0] e);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.exp = e;
    return v;
  endfunction

  initial begin
    rst = 1'b1; addr = '0; w_data = '0; w_en = 1'b0; r_en = 1'b0;

    // Reset values
    tbl.push_back(mk(OP_RD, 8'h80, 0, 32'h0));
    tbl.push_back(mk(OP_RD, 8'h84, 0, 32'h0));
    tbl.push_back(mk(OP_RD, 8'h88, 0, 32'h0));
    tbl.push_back(mk(OP_RD, 8'h8C, 0, 32'h0));
    tbl.push_back(mk(OP_RD, 8'h00, 0, 32'h0));
    // A=[1,2,3,4] B=[5,6,7,8], LEN=4 -> 70
    tbl.push_back(mk(OP_WR, 8'h00, 1, 0));
    tbl.push_back(mk(OP_WR, 8'h04, 2, 0));
    tbl.push_back(mk(OP_WR, 8'h08, 3, 0));
    tbl.push_back(mk(OP_WR, 8'h0C, 4, 0));
    tbl.push_back(mk(OP_WR, 8'h40, 5, 0));
    tbl.push_back(mk(OP_WR, 8'h44, 6, 0));
    tbl.push_back(mk(OP_WR, 8'h48, 7, 0));
    tbl.push_back(mk(OP_WR, 8'h4C, 8, 0));
    tbl.push_back(mk(OP_RD, 8'h08, 0, 32'd3));
    tbl.push_back(mk(OP_RD, 8'h4E, 0, 32'd8));
    tbl.push_back(mk(OP_WR, 8'h80, 32'h0401, 0));
    tbl.push_back(mk(OP_IDLE, 0, 8, 0));
    tbl.push_back(mk(OP_RD, 8'h84, 0, 32'h2));
    tbl.push_back(mk(OP_RD, 8'h88, 0, 32'd70));
    tbl.push_back(mk(OP_RD, 8'h8C, 0, 32'h0));
    tbl.push_back(mk(OP_RD, 8'h80, 0, 32'h0400));
    // Clear DONE -> idle
    tbl.push_back(mk(OP_WR, 8'h84, 32'h2, 0));
    tbl.push_back(mk(OP_RD, 8'h84, 0, 32'h0));
    // ACCUM run -> 140
    tbl.push_back(mk(OP_WR, 8'h80, 32'h0403, 0));
    tbl.push_back(mk(OP_IDLE, 0, 8, 0));
    tbl.push_back(mk(OP_RD, 8'h88, 0, 32'd140));
    tbl.push_back(mk(OP_RD, 8'h80, 0, 32'h0402));
    // Fresh run; RESULT shadowed while busy; operand/CTRL writes ignored while busy
    tbl.push_back(mk(OP_WR, 8'h80, 32'h0401, 0));
    tbl.push_back(mk(OP_RD, 8'h88, 0, 32'd140));
    tbl.push_back(mk(OP_WR, 8'h00, 32'd99, 0));
    tbl.push_back(mk(OP_WR, 8'h80, 32'h0403, 0));
    tbl.push_back(mk(OP_IDLE, 0, 8, 0));
    tbl.push_back(mk(OP_RD, 8'h88, 0, 32'd70));
    tbl.push_back(mk(OP_RD, 8'h00, 0, 32'd1));
    tbl.push_back(mk(OP_RD, 8'h84, 0, 32'h2));
    // A=[-3,2] B=[4,-5], LEN=2 -> -22
    tbl.push_back(mk(OP_WR, 8'h00, 32'h0000FFFD, 0));
    tbl.push_back(mk(OP_WR, 8'h40, 32'd4, 0));
    tbl.push_back(mk(OP_WR, 8'h44, 32'h0000FFFB, 0));
    tbl.push_back(mk(OP_WR, 8'h80, 32'h0201, 0));
    tbl.push_back(mk(OP_IDLE, 0, 6, 0));
    tbl.push_back(mk(OP_RD, 8'h88, 0, 32'hFFFFFFEA));
    tbl.push_back(mk(OP_RD, 8'h8C, 0, 32'hFFFFFFFF));
    tbl.push_back(mk(OP_RD, 8'h00, 0, 32'hFFFFFFFD));
    // LEN=0 and LEN=9 both mean all 8 elements: -12-10+21+32 = 31
    tbl.push_back(mk(OP_WR, 8'h80, 32'h0001, 0));
    tbl.push_back(mk(OP_IDLE, 0, 12, 0));
    tbl.push_back(mk(OP_RD, 8'h88, 0, 32'd31));
    tbl.push_back(mk(OP_WR, 8'h80, 32'h0901, 0));
    tbl.push_back(mk(OP_IDLE, 0, 12, 0));
    tbl.push_back(mk(OP_RD, 8'h88, 0, 32'd31));
    tbl.push_back(mk(OP_RD, 8'h80, 0, 32'h0900));
    // Unmapped addresses
    tbl.push_back(mk(OP_RD, 8'h90, 0, 32'h0));
    tbl.push_back(mk(OP_RD, 8'h20, 0, 32'h0));
    tbl.push_back(mk(OP_RD, 8'hFC, 0, 32'h0));

    idle(2);
    rst = 1'b0;

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        OP_WR: wr(tbl[i].addr, tbl[i].data);
        OP_RD: begin
          rd(tbl[i].addr);
          chk($sformatf("vec%0d@%02h", i, tbl[i].addr), r_data, tbl[i].exp);
        end
        default: idle(int'(tbl[i].data));
      endcase
    end

    // DONE becomes visible exactly LEN+1 edges after the START edge (LEN=4)
    wr(8'h00, 1); wr(8'h04, 2); wr(8'h40, 5); wr(8'h44, 6);
    wr(8'h80, 32'h0401);
    idle(4);
    rd(8'h84); chk("status_edge5_busy", r_data, 32'h1);
    rd(8'h84); chk("status_edge6_done", r_data, 32'h2);
    rd(8'h88); chk("timing_result", r_data, 32'd70);
`ifdef ML_VEC_MAC_IRQ_EN
    chk("irq_ie_off", {31'b0, irq}, 32'h0);
`endif

    // Simultaneous write and read return the pre-write value
    rw(8'h04, 32'h77);
    chk("rw_prewrite", r_data, 32'd2);
    rd(8'h04); chk("rw_postwrite", r_data, 32'h77);

    // All operands -32768, LEN=4: 2^32 fits in 40 bits, wraps with OVF in 32 bits
    for (int i = 0; i < 4; i++) begin
      wr(8'(4 * i), 32'h8000);
      wr(8'(8'h40 + 4 * i), 32'h8000);
    end
    wr(8'h80, 32'h0401);
    idle(8);
    rd(8'h84);
    chk("ovf40_status", r_data, 32'h2);
    chk("ovf32_status", r_data32, 32'h6);
    rd(8'h88);
    chk("ovf40_lo", r_data, 32'h0);
    chk("ovf32_lo", r_data32, 32'h0);
    rd(8'h8C);
    chk("ovf40_hi", r_data, 32'h1);
    chk("ovf32_hi", r_data32, 32'h0);
    wr(8'h84, 32'h4);
    rd(8'h84); chk("ovf32_clr", r_data32, 32'h2);

`ifdef ML_VEC_MAC_IRQ_EN
    wr(8'h80, 32'h0405);
    idle(8);
    chk("irq_level", {31'b0, irq}, 32'h1);
    wr(8'h84, 32'h2);
    idle(1);
    chk("irq_clear", {31'b0, irq}, 32'h0);
`endif
    wr(8'h84, 32'h6);
    rd(8'h84); chk("status_clr_all", r_data, 32'h0);

    // Reset two edges into RUN aborts with no DONE or irq
    wr(8'h80, 32'h0405);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
`ifdef ML_VEC_MAC_IRQ_EN
      chk($sformatf("abort_irq%0d", i), {31'b0, irq}, 32'h0);
`endif
    end
    rd(8'h84); chk("abort_status", r_data, 32'h0);
    rd(8'h88); chk("abort_lo", r_data, 32'h0);
    rd(8'h8C); chk("abort_hi", r_data, 32'h0);
    rd(8'h80); chk("abort_ctrl", r_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ml_vec_mac.md
ML_VEC_MAC -- requirements
Module: ml_vec_mac

Interface
REQ-001 SHALL have parameter VEC_LEN, default 8, max operand elements (1..16).
REQ-002 SHALL have parameter DATA_W, default 16, signed operand width.
REQ-003 SHALL have parameter ACC_W, default 40, signed accumulator width (>= 2*DATA_W).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port addr  input  8  byte address, word aligned (addr[1:0] ignored).
REQ-007 SHALL have port w_data  input  32  write data.
REQ-008 SHALL have port w_en  input  1  write strobe, sampled each edge.
REQ-009 SHALL have port r_en  input  1  read strobe, sampled each edge.
REQ-010 SHALL have port r_data  output  32  registered read data.
REQ-011 SHALL have port irq  output  1  completion interrupt (only with ML_VEC_MAC_IRQ_EN).

Function
REQ-012 SHALL map A[i] at 0x00+4i, B[i] at 0x40+4i, CTRL 0x80, STATUS 0x84, RESULT_LO 0x88, RESULT_HI 0x8C; operands use w_data[DATA_W-1:0].
REQ-013 SHALL decode CTRL: bit0 START (self-clearing), bit1 ACCUM, bit2 IE, bits[12:8] LEN; LEN=0 or LEN>VEC_LEN means VEC_LEN.
REQ-014 SHALL decode STATUS: bit0 BUSY, bit1 DONE, bit2 OVF; writing 1 to bit1/bit2 clears that bit.
REQ-015 SHALL implement FSM IDLE, RUN, DONE; IDLE/DONE -> RUN on CTRL write with START=1; RUN -> DONE after LEN products; DONE -> IDLE on DONE clear.
REQ-016 SHALL clear accumulator and OVF on entry to RUN unless ACCUM=1, in which case prior result is retained as the starting value.
REQ-017 SHALL add one signed product A[k]*B[k] per RUN cycle, k = 0..LEN-1, sign-extended to ACC_W, wrapping two's complement.
REQ-018 SHALL set sticky OVF when any accumulate step signed-overflows ACC_W.
REQ-019 SHALL make DONE visible in STATUS exactly LEN+1 edges after the edge sampling the START write.
REQ-020 SHALL return RESULT_LO = acc[31:0], RESULT_HI = acc sign-extended bits [63:32].
REQ-021 SHALL update r_data on the edge sampling r_en and hold it otherwise; unmapped addresses read 0.
REQ-022 SHALL ignore operand and CTRL writes while BUSY; STATUS clears are honoured at any time except DONE clear while BUSY.
REQ-023 SHALL, on simultaneous w_en and r_en, perform both; r_data returns the pre-write value.
REQ-024 SHALL read RESULT as the last completed value while BUSY (accumulator shadowed until DONE).

Reset
REQ-025 SHALL on rst: state IDLE, all operand regs, CTRL, STATUS, accumulator, result, r_data 0, irq 0.
REQ-026 SHALL abort an in-progress RUN on rst with no DONE or irq generated.

Configuration
REQ-027 SHALL with ML_VEC_MAC_IRQ_EN defined drive irq = DONE & IE, level, registered.
REQ-028 SHALL without ML_VEC_MAC_IRQ_EN omit the irq port and read CTRL bit2 as 0.

Structure
REQ-029 SHALL place FSM state enum, register offsets and CTRL/STATUS bit positions in package ml_vec_mac_pkg.
REQ-030 SHALL implement the multiply-accumulate datapath and overflow detection in sub-module ml_mac_unit.

Verification
REQ-031 SHALL cover: A=[1,2,3,4], B=[5,6,7,8], CTRL=0x0401 -> DONE after 5 edges, RESULT_LO=70, RESULT_HI=0.
REQ-032 SHALL cover: A=[-3,2], B=[4,-5], LEN=2 -> RESULT_LO=0xFFFFFFEA (-22), RESULT_HI=0xFFFFFFFF.
REQ-033 SHALL cover: after 70, CTRL=0x0403 (ACCUM) same operands -> RESULT_LO=140.
REQ-034 SHALL cover: write A0=99 and START while BUSY -> ignored, result unchanged at 70.
REQ-035 SHALL cover: DATA_W=16, ACC_W=32, LEN=4, all operands -32768 -> 4*2^30 wraps, OVF=1.
REQ-036 SHALL cover: rst asserted 2 edges into RUN -> STATUS=0, RESULT=0, irq stays 0.
